// File: rtl/arb_burst_requester.sv
// Per-port burst front end for the 3-way arbiter: queues burst commands, drives req and counts
// granted beats. Define ARB_REQ_TIMEOUT_EN to build the starvation counter behind `starve`.
module arb_burst_requester #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_W-1:0]           cmd_len,
    output logic                       req,
    input  logic                       gnt,
    output logic                       beat,
    output logic [LEN_W-1:0]           beat_idx,
    output logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       starve
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);
    localparam logic [LEN_W:0] RemOne = (LEN_W + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LEN_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("arb_burst_requester: DEPTH must be a power of two >= 2, LEN_W and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic [LEN_W:0]   rem_q, rem_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] head;
    logic             push, pop;

    assign push = cmd_valid && cmd_ready;
    // Only IDLE and DRAIN load a new burst; the head is always a registered entry.
    assign pop  = (state_q != StActive) && (level_q != '0);
    assign head = mem[rd_ptr_q];

    // Command FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= cmd_len;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LvlW'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LvlW'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (gnt && (rem_q == RemOne)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = pop ? StActive : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs decoded from state
    always_comb begin
        req       = 1'b0;
        done      = 1'b0;
        case (state_q)
            StActive: req  = 1'b1;
            StDrain:  done = 1'b1;
            default:  ;
        endcase
        // A late grant while req is low never counts as a beat.
        beat      = req && gnt;
        beat_idx  = idx_q;
        busy      = (state_q != StIdle) || (level_q != '0);
        level     = level_q;
        cmd_ready = (level_q != FullLvl);
    end

    // Beat bookkeeping
    always_comb begin
        rem_d = rem_q;
        idx_d = idx_q;
        if (pop) begin
            rem_d = {1'b0, head} + RemOne;
            idx_d = '0;
        end else if (beat) begin
            rem_d = rem_q - RemOne;
            // Hold the index on the final beat so a full-length burst does not wrap it.
            if (rem_q != RemOne) begin
                idx_d = idx_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rem_q <= '0;
            idx_q <= '0;
        end else begin
            rem_q <= rem_d;
            idx_q <= idx_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    // Counts consecutive ungranted ACTIVE cycles; any beat or leaving ACTIVE clears it.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == StActive) && !gnt) begin
            wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign starve = (wait_cnt_q >= CntLimit);
`else
    assign starve = 1'b0;
`endif

endmodule
